rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_pkg.sv | 16 +
 rtl/rst_seq_cnt.sv | 24 ++
 rtl/rst_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing for the reset sequencer.
package rst_seq_pkg;

  localparam int unsigned ASSERT_MIN = 16;
  localparam int unsigned NUM_DOM    = 3;
  localparam int unsigned DLY_W      = 8;

  typedef enum logic [2:0] {
    ASSERT = 3'd0,
    REL0   = 3'd1,
    REL1   = 3'd2,
    REL2   = 3'd3,
    RUN    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable saturating down-counter with zero flag; reinitialised by the parent via load.
module rst_seq_cnt
  import rst_seq_pkg::*;
(
  input  logic             clk,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [DLY_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DLY_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-on style reset sequencer: holds all domains in reset, then releases
// domains 0,1,2 in order spaced by a sampled delay.
module rst_seq_ctrl
  import rst_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_rst_req,
  input  logic [DLY_W-1:0]   dly_cfg,
  input  logic [NUM_DOM-1:0] hold_mask,
  output logic [NUM_DOM-1:0] rst_out,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               req_ack
);

  seq_state_t         state, state_nxt;
  logic [NUM_DOM-1:0] rel_q, rel_nxt;
  logic [DLY_W-1:0]   d_q, d_nxt;
  logic               done_nxt, ack_nxt;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DLY_W-1:0]   cnt_val;

  rst_seq_cnt u_cnt (
    .clk      (clk),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ASSERT;
      rel_q    <= '0;
      d_q      <= DLY_W'(1);
      seq_busy <= 1'b1;
      seq_done <= 1'b0;
      req_ack  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rel_q    <= rel_nxt;
      d_q      <= d_nxt;
      seq_busy <= (state_nxt != RUN);
      seq_done <= done_nxt;
      req_ack  <= ack_nxt;
    end
  end

  // Next-state, release and counter control; the counter counts ASSERT_MIN-1..0
  // in ASSERT and D-1..0 in each release state.
  always_comb begin
    state_nxt = state;
    rel_nxt   = rel_q;
    d_nxt     = d_q;
    done_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = DLY_W'(ASSERT_MIN - 1);

    if (!rst) begin
      cnt_load = 1'b1;
    end else begin
      unique case (state)
        ASSERT: begin
          if (cnt_zero) begin
            state_nxt = REL0;
            d_nxt     = (dly_cfg == '0) ? DLY_W'(1) : dly_cfg;
            cnt_load  = 1'b1;
            cnt_val   = d_nxt - DLY_W'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        REL0: begin
          if (cnt_zero) begin
            state_nxt  = REL1;
            rel_nxt[0] = 1'b1;
            cnt_load   = 1'b1;
            cnt_val    = d_q - DLY_W'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        REL1: begin
          if (cnt_zero) begin
            state_nxt  = REL2;
            rel_nxt[1] = 1'b1;
            cnt_load   = 1'b1;
            cnt_val    = d_q - DLY_W'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        REL2: begin
          if (cnt_zero) begin
            state_nxt  = RUN;
            rel_nxt[2] = 1'b1;
            done_nxt   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        RUN: begin
          if (ext_rst_req) begin
            state_nxt = ASSERT;
            rel_nxt   = '0;
            ack_nxt   = 1'b1;
            cnt_load  = 1'b1;
          end
        end
        default: begin
          state_nxt = ASSERT;
          rel_nxt   = '0;
          cnt_load  = 1'b1;
        end
      endcase
    end
  end

  // Hold mask overrides the sequenced value without touching FSM timing
  assign rst_out = rel_q & ~hold_mask;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: release timing, re-sequencing, masking and reset.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ext_rst_req;
  logic [7:0] dly_cfg;
  logic [2:0] hold_mask;
  logic [2:0] rst_out;
  logic       seq_busy;
  logic       seq_done;
  logic       req_ack;

  int n_chk = 0;
  int n_bad = 0;

  rst_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ext_rst_req (ext_rst_req),
    .dly_cfg     (dly_cfg),
    .hold_mask   (hold_mask),
    .rst_out     (rst_out),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .req_ack     (req_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Five reset cycles; the next edge is edge 1
  task automatic do_reset();
    rst = 1'b0;
    repeat (5) step();
    chk("rst_out_in_reset", 16'(rst_out), 16'h0);
    chk("busy_in_reset", 16'(seq_busy), 16'h1);
    chk("done_in_reset", 16'(seq_done), 16'h0);
    chk("ack_in_reset", 16'(req_ack), 16'h0);
    rst = 1'b1;
  endtask

  // Checks edges first..last against hand-derived release times 16+k*d
  task automatic run_seq(input string name, input int d, input logic [2:0] mask,
                         input int first, input int last);
    logic [2:0] exp_rst;
    for (int e = first; e <= last; e++) begin
      step();
      for (int i = 0; i < 3; i++)
        exp_rst[i] = (e >= 16 + (i + 1) * d) && !mask[i];
      chk($sformatf("%s_rst_out_e%0d", name, e), 16'(rst_out), 16'(exp_rst));
      chk($sformatf("%s_done_e%0d", name, e), 16'(seq_done), 16'(e == 16 + 3 * d));
      chk($sformatf("%s_busy_e%0d", name, e), 16'(seq_busy), 16'(e < 16 + 3 * d));
      chk($sformatf("%s_ack_e%0d", name, e), 16'(req_ack), 16'h0);
    end
  endtask

  initial begin
    rst         = 1'b0;
    ext_rst_req = 1'b0;
    dly_cfg     = 8'd4;
    hold_mask   = 3'b000;

    // Basic sequence with D=4, then hold in RUN
    do_reset();
    run_seq("d4", 4, 3'b000, 1, 30);

    // One-cycle request in RUN, re-sequence with D=2
    ext_rst_req = 1'b1;
    dly_cfg     = 8'd2;
    step();
    ext_rst_req = 1'b0;
    chk("req_ack_pulse", 16'(req_ack), 16'h1);
    chk("req_rst_out", 16'(rst_out), 16'h0);
    chk("req_busy", 16'(seq_busy), 16'h1);
    run_seq("req_d2", 2, 3'b000, 1, 24);

    // dly_cfg=0 behaves as D=1
    dly_cfg = 8'd0;
    do_reset();
    run_seq("d0", 1, 3'b000, 1, 21);

    // Reset mid-sequence, then full restart
    dly_cfg = 8'd10;
    do_reset();
    run_seq("d10_pre", 10, 3'b000, 1, 29);
    rst = 1'b0;
    step();
    chk("mid_rst_out", 16'(rst_out), 16'h0);
    chk("mid_busy", 16'(seq_busy), 16'h1);
    chk("mid_done", 16'(seq_done), 16'h0);
    rst = 1'b1;
    run_seq("d10_post", 10, 3'b000, 1, 48);

    // Hold mask on domain 1, cleared in RUN
    dly_cfg   = 8'd3;
    hold_mask = 3'b010;
    do_reset();
    run_seq("mask", 3, 3'b010, 1, 27);
    hold_mask = 3'b000;
    step();
    chk("mask_clear", 16'(rst_out), 16'h7);

    // Request held from edge 1: ignored until RUN, then repeats
    dly_cfg     = 8'd1;
    ext_rst_req = 1'b1;
    do_reset();
    run_seq("held1", 1, 3'b000, 1, 19);
    step();
    chk("held_ack1", 16'(req_ack), 16'h1);
    chk("held_rst1", 16'(rst_out), 16'h0);
    run_seq("held2", 1, 3'b000, 1, 19);
    step();
    chk("held_ack2", 16'(req_ack), 16'h1);
    ext_rst_req = 1'b0;
    run_seq("held3", 1, 3'b000, 1, 21);

    // Maximum delay
    dly_cfg = 8'd255;
    do_reset();
    run_seq("d255", 255, 3'b000, 1, 783);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
